// File: rtl/result_unloader_if.sv
`default_nettype none
// ============================================================================
// Module      : result_unloader_if
// Description : Bundles the result-unloader data path: compute-side result
//               input, capture enable, raw host acknowledge and the queue view.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_unloader_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         res_in;
    logic                     capture_en;
    logic                     ack_pin;
    logic [WIDTH-1:0]         dout;
    logic                     dout_valid;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;

    // The environment drives results and the host acknowledge.
    modport master (
        output res_in,
        output capture_en,
        output ack_pin,
        input  dout,
        input  dout_valid,
        input  level,
        input  overflow
    );

    // The unloader consumes results and presents the queue head.
    modport slave (
        input  res_in,
        input  capture_en,
        input  ack_pin,
        output dout,
        output dout_valid,
        output level,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/result_unloader.sv
`default_nettype none
// ============================================================================
// Module      : result_unloader
// Description : Queues every new compute result in a small FIFO and pops the
//               head on each rising edge of an asynchronous host acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module result_unloader #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    result_unloader_if.slave   bus
);

    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam int                 c_cnt_w    = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]       res_q,      res_d;
    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic                   ack_prev_q, ack_prev_d;
    logic [c_ptr_w-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [c_ptr_w-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [c_cnt_w-1:0]     count_q,    count_d;
    logic                   overflow_q, overflow_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic                   w_ack_sync;
    logic                   w_push_req;
    logic                   w_pop_req;
    logic                   w_push_acc;
    logic                   w_pop_acc;

    always_comb begin
        w_ack_sync = sync_q[SYNC_STAGES-1];
        w_push_req = bus.capture_en && (bus.res_in != res_q);
        w_pop_req  = w_ack_sync && !ack_prev_q;
        w_pop_acc  = w_pop_req && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        w_push_acc = w_push_req && ((count_q != c_cnt_full) || w_pop_acc);

        res_d      = bus.res_in;
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.ack_pin};
        ack_prev_d = w_ack_sync;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (w_push_acc) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_pop_acc) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        if (w_push_acc && !w_pop_acc) begin
            count_d = count_q + c_cnt_one;
        end else if (w_pop_acc && !w_push_acc) begin
            count_d = count_q - c_cnt_one;
        end
        if (w_push_req && !w_push_acc) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q      <= '0;
            sync_q     <= '0;
            ack_prev_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            res_q      <= res_d;
            sync_q     <= sync_d;
            ack_prev_q <= ack_prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; the output mux hides stale entries while empty.
    always_ff @(posedge clk) begin
        if (!rst && w_push_acc) begin
            mem_q[wr_ptr_q] <= bus.res_in;
        end
    end

    assign bus.dout       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.dout_valid = (count_q != '0);
    assign bus.level      = count_q;
    assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_result_unloader.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_unloader
// Description : Directed stimulus with a cycle-stamped expectation queue and an
//               independent monitor that also flags any unannounced change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_unloader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_unloader_if #(.WIDTH(4), .DEPTH(4)) bus ();

    result_unloader #(
        .WIDTH       (4),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] d;
        logic       v;
        logic [2:0] l;
        logic       o;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [8:0] prev;
    bit         have_prev = 0;

    // Monitor: compare the cycle-stamped expectation, reject unexplained changes.
    always @(negedge clk) begin
        logic [8:0] cur;
        bit         matched;
        exp_t       e;
        cur     = {bus.dout, bus.dout_valid, bus.level, bus.overflow};
        matched = 0;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d was never sampled (now %0d)", e.tag, e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            checks++;
            matched = 1;
            if (cur !== {e.d, e.v, e.l, e.o}) begin
                errors++;
                $display("FAIL %s @cyc %0d: got dout=%h valid=%b level=%0d ovf=%b, want dout=%h valid=%b level=%0d ovf=%b",
                         e.tag, cyc, bus.dout, bus.dout_valid, bus.level, bus.overflow, e.d, e.v, e.l, e.o);
            end
        end
        if (!matched && have_prev && cur !== prev) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change @cyc %0d: got dout=%h valid=%b level=%0d ovf=%b, want unchanged %h",
                     cyc, bus.dout, bus.dout_valid, bus.level, bus.overflow, prev);
        end
        prev      = cur;
        have_prev = 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input logic [3:0] d, input logic v,
                             input logic [2:0] l, input logic o, input string tag);
        exp_t e;
        e.cyc = c; e.d = d; e.v = v; e.l = l; e.o = o; e.tag = tag;
        q.push_back(e);
    endtask

    // Drive a new result; the capture lands on the very next edge.
    task automatic cap(input logic [3:0] val, input logic [3:0] d, input logic v,
                       input logic [2:0] l, input logic o, input string tag);
        bus.res_in = val;
        expect_at(cyc + 1, d, v, l, o, tag);
        step();
    endtask

    task automatic pulse(input int hi, input int lo);
        bus.ack_pin = 1'b1;
        repeat (hi) step();
        bus.ack_pin = 1'b0;
        repeat (lo) step();
    endtask

    // Ack rises before edge cyc+1, so the pop lands at edge cyc+3.
    task automatic ack_exp(input logic [3:0] d, input logic v, input logic [2:0] l,
                           input logic o, input string tag);
        expect_at(cyc + 3, d, v, l, o, tag);
        pulse(4, 4);
    endtask

    initial begin
        rst            = 1'b1;
        bus.res_in     = 4'h7;
        bus.capture_en = 1'b1;
        bus.ack_pin    = 1'b0;

        // Reset held for two edges, then the 0->7 difference is captured.
        expect_at(1, 4'h0, 1'b0, 3'd0, 1'b0, "reset_e1");
        expect_at(2, 4'h0, 1'b0, 3'd0, 1'b0, "reset_e2");
        step();
        step();
        rst = 1'b0;
        expect_at(cyc + 1, 4'h7, 1'b1, 3'd1, 1'b0, "post_reset_cap7");
        step();
        ack_exp(4'h0, 1'b0, 3'd0, 1'b0, "pop7");

        // Ordered drain: 3, 9 (held three cycles), A.
        cap(4'h3, 4'h3, 1'b1, 3'd1, 1'b0, "cap3");
        cap(4'h9, 4'h3, 1'b1, 3'd2, 1'b0, "cap9");
        step();
        step();
        cap(4'hA, 4'h3, 1'b1, 3'd3, 1'b0, "capA");
        ack_exp(4'h9, 1'b1, 3'd2, 1'b0, "drain_9");
        ack_exp(4'hA, 1'b1, 3'd1, 1'b0, "drain_A");
        ack_exp(4'h0, 1'b0, 3'd0, 1'b0, "drain_empty");

        // Overflow: fifth capture is dropped.
        cap(4'h1, 4'h1, 1'b1, 3'd1, 1'b0, "ovf_cap1");
        cap(4'h2, 4'h1, 1'b1, 3'd2, 1'b0, "ovf_cap2");
        cap(4'h3, 4'h1, 1'b1, 3'd3, 1'b0, "ovf_cap3");
        cap(4'h4, 4'h1, 1'b1, 3'd4, 1'b0, "ovf_cap4");
        cap(4'h5, 4'h1, 1'b1, 3'd4, 1'b1, "ovf_drop5");
        ack_exp(4'h2, 1'b1, 3'd3, 1'b1, "ovf_pop_2");
        ack_exp(4'h3, 1'b1, 3'd2, 1'b1, "ovf_pop_3");
        ack_exp(4'h4, 1'b1, 3'd1, 1'b1, "ovf_pop_4");
        ack_exp(4'h0, 1'b0, 3'd0, 1'b1, "ovf_empty");

        // Reset to clear the sticky overflow.
        bus.capture_en = 1'b0;
        bus.res_in     = 4'h0;
        rst            = 1'b1;
        expect_at(cyc + 1, 4'h0, 1'b0, 3'd0, 1'b0, "ovf_reset");
        step();
        rst            = 1'b0;
        bus.capture_en = 1'b1;
        step();

        // Simultaneous push and pop while full.
        cap(4'h1, 4'h1, 1'b1, 3'd1, 1'b0, "full_cap1");
        cap(4'h2, 4'h1, 1'b1, 3'd2, 1'b0, "full_cap2");
        cap(4'h3, 4'h1, 1'b1, 3'd3, 1'b0, "full_cap3");
        cap(4'h4, 4'h1, 1'b1, 3'd4, 1'b0, "full_cap4");
        bus.ack_pin = 1'b1;
        step();
        step();
        cap(4'h6, 4'h2, 1'b1, 3'd4, 1'b0, "full_push_pop");
        step();
        bus.ack_pin = 1'b0;
        repeat (4) step();
        ack_exp(4'h3, 1'b1, 3'd3, 1'b0, "full_pop_3");
        ack_exp(4'h4, 1'b1, 3'd2, 1'b0, "full_pop_4");
        ack_exp(4'h6, 1'b1, 3'd1, 1'b0, "full_pop_6");
        ack_exp(4'h0, 1'b0, 3'd0, 1'b0, "full_empty");

        // Ack held high for 20 cycles pops exactly once.
        cap(4'h7, 4'h7, 1'b1, 3'd1, 1'b0, "hold_cap7");
        cap(4'h8, 4'h7, 1'b1, 3'd2, 1'b0, "hold_cap8");
        bus.ack_pin = 1'b1;
        expect_at(cyc + 3, 4'h8, 1'b1, 3'd1, 1'b0, "hold_single_pop");
        repeat (20) step();
        bus.ack_pin = 1'b0;
        repeat (4) step();
        ack_exp(4'h0, 1'b0, 3'd0, 1'b0, "hold_drain");

        // Ack while empty changes nothing; a later capture still works.
        pulse(4, 4);
        cap(4'h5, 4'h5, 1'b1, 3'd1, 1'b0, "empty_ack_cap5");

        // Reset lands on the pop edge; held ack must not pop afterwards.
        cap(4'h6, 4'h5, 1'b1, 3'd2, 1'b0, "mid_cap6");
        cap(4'h7, 4'h5, 1'b1, 3'd3, 1'b0, "mid_cap7");
        bus.ack_pin = 1'b1;
        step();
        bus.capture_en = 1'b0;
        step();
        rst = 1'b1;
        expect_at(cyc + 1, 4'h0, 1'b0, 3'd0, 1'b0, "mid_reset");
        step();
        rst = 1'b0;
        repeat (10) step();
        bus.ack_pin = 1'b0;
        repeat (5) step();

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", e.tag, e.cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
